sd_rx_fifo_packer: RTL and testbench
====================================

Name: sd_rx_fifo_packer

Overview:
- Receive-side FIFO for the SD data path.
- Accepts 4-bit nibbles from the SD serial/data block, packs each group of 8 nibbles into a 32-bit word, and queues words for the RX filler, which drains them to a Wishbone master.
- The read port is first-word-fall-through: the head word is always present on q while not empty.

Parameters:
- DATA_W, 4, input nibble width; equals SD_BUS_W.
- WORD_W, 32, output word width; must be a multiple of DATA_W. NIB_PER_WORD = WORD_W/DATA_W = 8.
- DEPTH, 8, number of 32-bit words stored; power of two.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk, input, 1: single clock for both write and read sides. All logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-low.
- d, input, DATA_W: nibble to write.
- wr, input, 1: write strobe, one nibble per cycle while high.
- rd, input, 1: pop head word.
- q, output, WORD_W: head word (FWFT).
- full, output, 1: word storage holds DEPTH words.
- empty, output, 1: no complete word stored.
- mem_empt, output, 1: empty and no partial nibbles pending in the packer.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Clears write pointer, read pointer, word count, nibble counter and packing register.
  - Outputs after reset: empty=1, full=0, mem_empt=1, q=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words and any partial word.
- Packing:
  - A nibble is accepted on an edge where wr=1 and full=0. If full=1, the nibble is dropped and packer state is unchanged.
  - Nibbles are MSB-first: the 1st nibble of a word occupies bits [31:28], the 8th occupies [3:0].
  - The nibble counter (0..7) increments per accepted nibble and wraps 7->0.
  - On the edge accepting the 8th nibble, the complete word is written to mem[wr_ptr] and wr_ptr increments, wrapping modulo DEPTH.
  - Latency: the completed word is visible on q (if it is the head) and empty falls in the cycle after that edge.
- Reading:
  - Pop on an edge where rd=1 and empty=0: rd_ptr increments (wraps) and the count decrements.
  - rd while empty is ignored.
  - q = mem[rd_ptr] combinationally when empty=0, else 0. After a pop, q shows the next word in the following cycle.
- Count and flags:
  - Word count ranges 0..DEPTH.
  - Simultaneous word-complete and pop on the same edge: count unchanged, both pointers advance.
  - full = (count==DEPTH); empty = (count==0). Both derive from registered state and carry no combinational path from wr/rd.
  - When full=1 and rd=1 on the same edge: the pop occurs and any wr that cycle is dropped, because full was high. full falls the next cycle.
  - mem_empt = empty and (nibble counter == 0).
- Pointer wrap: exactly DEPTH words are written before full asserts; read order equals write order across wrap-around.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> empty=1, full=0, mem_empt=1, q=0.
- Single word: write nibbles 1,2,3,4,5,6,7,8 on consecutive cycles -> after the 1st nibble mem_empt=0, empty=1; one cycle after the 8th, empty=0 and q=32'h12345678. Pulse rd -> next cycle empty=1, mem_empt=1, q=0.
- Fill: write 8 words (64 nibbles) with values 32'h0000000k, k=0..7 -> full=1 after the last. A further 8 nibbles of F are dropped. Reading 8 words returns k=0..7 in order, then empty=1.
- Wrap: repeat write-3-words / read-3-words cycles 5 times -> data always in order; pointers cross the DEPTH boundary with no loss; count never exceeds 3.
- Simultaneous: with 1 word stored, assert rd on the same edge that the 8th nibble of the next word is accepted -> empty stays 0, q shows the new word next cycle, count remains 1.
- Reset mid-operation: store 2 words plus 3 nibbles, apply rst=0 for one edge -> empty=1, mem_empt=1. A fresh 8-nibble word 32'hA5A5A5A5 then reads back correctly, with no leftover nibbles in it.

Source files
------------

// File: rtl/sd_rx_fifo_packer.sv
// sd_rx_fifo_packer
//   Receive-side FIFO for the SD data path. Nibbles from the SD data block
//   are packed MSB-first into 32-bit words. Complete words are queued for
//   the RX filler, which drains them toward the Wishbone master. The read
//   port is first-word-fall-through: while words are stored, the head word
//   is always present on q.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous reset, active low
//   d        : nibble to write (DATA_W bits)
//   wr       : write strobe, one nibble per cycle while high
//   rd       : pop the head word
//   q        : head word (FWFT), zero while empty
//   full     : DEPTH words are stored
//   empty    : no complete word is stored
//   mem_empt : empty and no partial word pending in the packer
module sd_rx_fifo_packer #(
    parameter int DATA_W = 4,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    input  logic              wr,
    input  logic              rd,
    output logic [WORD_W-1:0] q,
    output logic              full,
    output logic              empty,
    output logic              mem_empt
);

    localparam int NIB_PER_WORD = WORD_W / DATA_W;
    localparam int NIB_W        = (NIB_PER_WORD > 1) ? $clog2(NIB_PER_WORD) : 1;
    localparam logic [NIB_W-1:0]  NIB_LAST  = NIB_W'(NIB_PER_WORD - 1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic [NIB_W-1:0]  nib_cnt_q, nib_cnt_d;
    logic [WORD_W-1:0] pack_q,    pack_d;

    logic accept;
    logic word_done;
    logic pop;

    // Flags come only from registered state, so there is no combinational
    // path from wr/rd to full/empty.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign mem_empt = empty && (nib_cnt_q == '0);

    // A nibble arriving while full is dropped without touching the packer.
    assign accept    = wr && !full;
    assign word_done = accept && (nib_cnt_q == NIB_LAST);
    assign pop       = rd && !empty;

    // Shifting left places the first nibble of a word in the top bits once
    // all nibbles have arrived; stale bits from the previous word are
    // shifted out completely, so the register needs no clearing on wrap.
    assign pack_d = accept ? {pack_q[WORD_W-DATA_W-1:0], d} : pack_q;

    always_comb begin
        nib_cnt_d = nib_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (accept) begin
            nib_cnt_d = (nib_cnt_q == NIB_LAST) ? '0 : nib_cnt_q + NIB_W'(1);
        end
        if (word_done) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        // Completion and pop on the same edge leave the count unchanged.
        unique case ({word_done, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            nib_cnt_q <= '0;
            pack_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            nib_cnt_q <= nib_cnt_d;
            pack_q    <= pack_d;
        end
    end

    // Storage is deliberately left out of reset; stale contents are never
    // visible because q is forced to zero while the count is zero.
    always_ff @(posedge clk) begin
        if (word_done && rst) begin
            mem[wr_ptr_q] <= pack_d;
        end
    end

    assign q = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_sd_rx_fifo_packer.sv
module tb_sd_rx_fifo_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  d;
    logic        wr;
    logic        rd;
    logic [31:0] q;
    logic        full;
    logic        empty;
    logic        mem_empt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_rx_fifo_packer #(
        .DATA_W(4),
        .WORD_W(32),
        .DEPTH (8),
        .ADDR_W(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .wr      (wr),
        .rd      (rd),
        .q       (q),
        .full    (full),
        .empty   (empty),
        .mem_empt(mem_empt)
    );

    // Inputs are applied 1 time unit after a rising edge; after the next
    // rising edge plus 1 the registered outputs are settled and sampled.
    task automatic tick(input logic w, input logic [3:0] n, input logic r);
        wr = w;
        d  = n;
        rd = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        d  = 4'h0;
    endtask

    task automatic write_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, w[31 - 4*i -: 4], 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(1'b0, 4'h0, 1'b0);
        tick(1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        tick(1'b0, 4'h0, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (mem_empt !== 1'b1) begin errors++; $display("FAIL reset_mem_empt got %b want 1", mem_empt); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q got %h want 00000000", q); end
        $display("reset: empty=%b full=%b mem_empt=%b q=%h", empty, full, mem_empt, q);
    endtask

    task automatic test_single_word();
        tick(1'b1, 4'h1, 1'b0);
        checks++; if (mem_empt !== 1'b0) begin errors++; $display("FAIL single_first_mem_empt got %b want 0", mem_empt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_first_empty got %b want 1", empty); end
        for (int i = 2; i <= 7; i++) tick(1'b1, 4'(i), 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_7th_empty got %b want 1", empty); end
        tick(1'b1, 4'h8, 1'b0);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_8th_empty got %b want 0", empty); end
        checks++; if (q !== 32'h12345678) begin errors++; $display("FAIL single_q got %h want 12345678", q); end
        $display("single word: q=%h empty=%b", q, empty);
        tick(1'b0, 4'h0, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b want 1", empty); end
        checks++; if (mem_empt !== 1'b1) begin errors++; $display("FAIL single_pop_mem_empt got %b want 1", mem_empt); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL single_pop_q got %h want 00000000", q); end
        $display("single pop: empty=%b mem_empt=%b q=%h", empty, mem_empt, q);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 8; k++) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_early_full word %0d got %b want 0", k, full); end
            write_word(32'(k));
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
        $display("fill: full=%b after 8 words", full);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'hF, 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_drop_full got %b want 1", full); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL fill_drop_q got %h want 00000000", q); end
        // Pop while full with a nibble offered: the nibble must be dropped.
        tick(1'b1, 4'h9, 1'b1);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_popfull_full got %b want 0", full); end
        $display("pop while full: full=%b q=%h", full, q);
        for (int k = 1; k < 8; k++) begin
            checks++; if (q !== 32'(k)) begin errors++; $display("FAIL fill_read word %0d got %h want %h", k, q, 32'(k)); end
            $display("fill read: q=%h", q);
            tick(1'b0, 4'h0, 1'b1);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_end_empty got %b want 1", empty); end
        checks++; if (mem_empt !== 1'b1) begin errors++; $display("FAIL fill_end_mem_empt got %b want 1 (dropped nibble leaked)", mem_empt); end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 3; j++) begin
                w = 32'hC0DE0000 | (32'(r) << 8) | 32'(j);
                write_word(w);
            end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full round %0d got %b want 0", r, full); end
            for (int j = 0; j < 3; j++) begin
                w = 32'hC0DE0000 | (32'(r) << 8) | 32'(j);
                checks++; if (q !== w) begin errors++; $display("FAIL wrap_q round %0d word %0d got %h want %h", r, j, q, w); end
                $display("wrap round %0d: q=%h", r, q);
                tick(1'b0, 4'h0, 1'b1);
            end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty round %0d got %b want 1", r, empty); end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] w2;
        w2 = 32'hDEADBEEF;
        write_word(32'h11112222);
        for (int i = 0; i < 7; i++) tick(1'b1, w2[31 - 4*i -: 4], 1'b0);
        checks++; if (q !== 32'h11112222) begin errors++; $display("FAIL simul_head got %h want 11112222", q); end
        tick(1'b1, w2[3:0], 1'b1);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL simul_empty got %b want 0", empty); end
        checks++; if (q !== w2) begin errors++; $display("FAIL simul_q got %h want %h", q, w2); end
        $display("simultaneous: q=%h empty=%b", q, empty);
        tick(1'b0, 4'h0, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_count got empty=%b want 1 (count 1)", empty); end
    endtask

    task automatic test_reset_mid();
        write_word(32'h01234567);
        write_word(32'h89ABCDEF);
        tick(1'b1, 4'h3, 1'b0);
        tick(1'b1, 4'h3, 1'b0);
        tick(1'b1, 4'h3, 1'b0);
        rst = 1'b0;
        tick(1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b want 1", empty); end
        checks++; if (mem_empt !== 1'b1) begin errors++; $display("FAIL rstmid_mem_empt got %b want 1", mem_empt); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rstmid_q got %h want 00000000", q); end
        write_word(32'hA5A5A5A5);
        checks++; if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL rstmid_fresh_q got %h want a5a5a5a5", q); end
        $display("reset mid-op: fresh q=%h", q);
        tick(1'b0, 4'h0, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_final_empty got %b want 1", empty); end
        checks++; if (mem_empt !== 1'b1) begin errors++; $display("FAIL rstmid_final_mem_empt got %b want 1", mem_empt); end
    endtask

    initial begin
        rst = 1'b0;
        wr  = 1'b0;
        rd  = 1'b0;
        d   = 4'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_word();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout after 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
